// File: rtl/uio_byte_rx.sv
// uio_byte_rx: receiving end of the 4-phase parallel byte handshake on the uio pins.
// Synchronises pin_req, captures pin_data into a small FIFO, acknowledges the
// sender, and presents bytes to the core over valid/ready.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   pin_data   byte from sender, stable while pin_req is high
//   pin_req    sender request (asynchronous to clk)
//   pin_ack    acknowledge to sender (registered)
//   out_data   FIFO head byte (registered, 0 while empty)
//   out_valid  FIFO non-empty (registered)
//   out_ready  core accepts the head byte this cycle
//   level      FIFO occupancy
//   frame_cnt  bytes accepted from the pins, wraps 255->0
module uio_byte_rx #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               pin_data,
  input  logic                     pin_req,
  output logic                     pin_ack,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               frame_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ACK     = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [SYNC_STAGES-1:0] req_sync;
  logic                 req_s;
  logic                 wr_en;
  logic                 rd_en;
  logic                 full;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr_next;
  logic [PW-1:0]        rd_ptr_next;
  logic [LW-1:0]        level_next;
  logic [AW-1:0]        head_idx;
  logic [7:0]           head_next;
  logic [7:0]           mem [DEPTH];

  // Request synchroniser; only the last stage is used downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_sync <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], pin_req};
    end
  end

  assign req_s = req_sync[SYNC_STAGES-1];

  // Full when pointers share an index but differ in the wrap bit.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = out_valid && out_ready;

  // Handshake FSM: next state and write strobe.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    case (state)
      IDLE: begin
        // Withhold the ack while full so the sender keeps the byte.
        if (req_s && !full) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        wr_en      = 1'b1;
        state_next = ACK;
      end
      ACK: begin
        if (!req_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Next FIFO bookkeeping and the head byte as it will look after this edge.
  always_comb begin
    wr_ptr_next = wr_ptr + PW'(wr_en);
    rd_ptr_next = rd_ptr + PW'(rd_en);
    level_next  = level + LW'(wr_en) - LW'(rd_en);
    head_idx    = rd_ptr_next[AW-1:0];
    if (level_next == '0) begin
      head_next = 8'h00;
    end else if (wr_en && (wr_ptr[AW-1:0] == head_idx)) begin
      // Byte being written lands straight at the head (FIFO was empty).
      head_next = pin_data;
    end else begin
      head_next = mem[head_idx];
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= pin_data;
    end
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pin_ack   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      frame_cnt <= 8'h00;
    end else begin
      state     <= state_next;
      pin_ack   <= (state_next == ACK);
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      level     <= level_next;
      out_valid <= (level_next != '0);
      out_data  <= head_next;
      frame_cnt <= frame_cnt + 8'(wr_en);
    end
  end

endmodule

// File: tb/tb_uio_byte_rx.sv
// Directed, table-driven bench for uio_byte_rx (DEPTH=4, SYNC_STAGES=2).
module tb_uio_byte_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pin_data;
  logic       pin_req;
  logic       pin_ack;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] level;
  logic [7:0] frame_cnt;

  int checks   = 0;
  int failures = 0;

  bit         mon_en = 1'b0;
  logic [7:0] sb_got [$];

  typedef struct {
    logic [7:0] data;
    bit         exp_ack;
    logic [2:0] exp_level;
    logic [7:0] exp_head;
    logic [7:0] exp_frame;
  } vec_t;

  uio_byte_rx #(.DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .pin_data  (pin_data),
    .pin_req   (pin_req),
    .pin_ack   (pin_ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  // Record every byte the core consumes while enabled.
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      sb_got.push_back(out_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Raise req with data and wait (bounded) for the ack; returns edges taken.
  task automatic handshake(input logic [7:0] d, input int budget, output bit acked, output int lat);
    pin_data = d;
    pin_req  = 1'b1;
    acked    = 1'b0;
    lat      = 0;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk);
      #1;
      if (pin_ack) begin
        acked = 1'b1;
        lat   = n;
        break;
      end
    end
  endtask

  // Drop req and wait (bounded) for the ack to fall.
  task automatic release_req();
    bit dropped;
    dropped = 1'b0;
    pin_req = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      if (!pin_ack) begin
        dropped = 1'b1;
        break;
      end
    end
    chk("ack_drop", 32'(dropped), 32'd1);
  endtask

  // Check head byte and pop it with a one-cycle ready pulse.
  task automatic drain_expect(input logic [7:0] d);
    chk("drain_valid", 32'(out_valid), 32'd1);
    chk("drain_data", 32'(out_data), 32'(d));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t       vecs [5];
    bit         acked;
    int         lat;
    logic [7:0] exp_frame;

    vecs[0] = '{data: 8'h01, exp_ack: 1'b1, exp_level: 3'd1, exp_head: 8'h01, exp_frame: 8'd2};
    vecs[1] = '{data: 8'h02, exp_ack: 1'b1, exp_level: 3'd2, exp_head: 8'h01, exp_frame: 8'd3};
    vecs[2] = '{data: 8'h03, exp_ack: 1'b1, exp_level: 3'd3, exp_head: 8'h01, exp_frame: 8'd4};
    vecs[3] = '{data: 8'h04, exp_ack: 1'b1, exp_level: 3'd4, exp_head: 8'h01, exp_frame: 8'd5};
    vecs[4] = '{data: 8'h05, exp_ack: 1'b0, exp_level: 3'd4, exp_head: 8'h01, exp_frame: 8'd5};

    rst       = 1'b1;
    pin_req   = 1'b0;
    pin_data  = 8'h00;
    out_ready = 1'b0;
    #12;
    chk("rst_ack", 32'(pin_ack), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_frame", 32'(frame_cnt), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single byte, with request-to-ack latency.
    handshake(8'hA5, 20, acked, lat);
    chk("single_ack", 32'(acked), 32'd1);
    chk("single_lat", 32'(lat), 32'd4);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'hA5);
    chk("single_level", 32'(level), 32'd1);
    chk("single_frame", 32'(frame_cnt), 32'd1);
    release_req();
    drain_expect(8'hA5);
    chk("single_empty_level", 32'(level), 32'd0);
    chk("single_empty_data", 32'(out_data), 32'd0);

    // Fill to full; the fifth request is held off.
    for (int i = 0; i < 5; i++) begin
      handshake(vecs[i].data, 12, acked, lat);
      chk("fill_ack", 32'(acked), 32'(vecs[i].exp_ack));
      chk("fill_level", 32'(level), 32'(vecs[i].exp_level));
      chk("fill_head", 32'(out_data), 32'(vecs[i].exp_head));
      chk("fill_frame", 32'(frame_cnt), 32'(vecs[i].exp_frame));
      if (vecs[i].exp_ack) begin
        release_req();
      end
    end

    // One pop frees a slot; the pending byte is then captured.
    chk("bp_head", 32'(out_data), 32'h01);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_pop_level", 32'(level), 32'd3);
    chk("bp_pop_head", 32'(out_data), 32'h02);
    handshake(8'h05, 12, acked, lat);
    chk("bp_ack", 32'(acked), 32'd1);
    chk("bp_lat", 32'(lat), 32'd2);
    chk("bp_level", 32'(level), 32'd4);
    chk("bp_frame", 32'(frame_cnt), 32'd6);
    release_req();
    drain_expect(8'h02);
    drain_expect(8'h03);
    drain_expect(8'h04);
    drain_expect(8'h05);
    chk("bp_empty", 32'(out_valid), 32'd0);
    exp_frame = 8'd6;

    // Read and write in the same cycle at level 2.
    handshake(8'h10, 20, acked, lat);
    release_req();
    handshake(8'h11, 20, acked, lat);
    release_req();
    exp_frame = exp_frame + 8'd2;
    chk("sim_pre_level", 32'(level), 32'd2);
    pin_data = 8'h12;
    pin_req  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("sim_capture_head", 32'(out_data), 32'h10);
    chk("sim_capture_ack", 32'(pin_ack), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp_frame = exp_frame + 8'd1;
    chk("sim_level", 32'(level), 32'd2);
    chk("sim_ack", 32'(pin_ack), 32'd1);
    chk("sim_head", 32'(out_data), 32'h11);
    chk("sim_frame", 32'(frame_cnt), 32'(exp_frame));
    release_req();
    drain_expect(8'h11);
    drain_expect(8'h12);
    chk("sim_empty", 32'(out_valid), 32'd0);

    // Request held long after the ack: exactly one capture.
    handshake(8'h33, 20, acked, lat);
    chk("held_ack", 32'(acked), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("held_ack_still", 32'(pin_ack), 32'd1);
    release_req();
    repeat (5) @(posedge clk);
    #1;
    exp_frame = exp_frame + 8'd1;
    chk("held_frame", 32'(frame_cnt), 32'(exp_frame));
    chk("held_level", 32'(level), 32'd1);
    drain_expect(8'h33);
    chk("held_empty", 32'(out_valid), 32'd0);

    // Reset while acknowledging with three bytes queued.
    handshake(8'h41, 20, acked, lat);
    release_req();
    handshake(8'h42, 20, acked, lat);
    release_req();
    handshake(8'h43, 20, acked, lat);
    chk("mid_pre_ack", 32'(acked), 32'd1);
    chk("mid_pre_level", 32'(level), 32'd3);
    rst = 1'b1;
    #1;
    chk("mid_ack", 32'(pin_ack), 32'd0);
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_level", 32'(level), 32'd0);
    chk("mid_frame", 32'(frame_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    handshake(8'h43, 20, acked, lat);
    chk("mid_re_ack", 32'(acked), 32'd1);
    chk("mid_re_lat", 32'(lat), 32'd4);
    chk("mid_re_level", 32'(level), 32'd1);
    chk("mid_re_frame", 32'(frame_cnt), 32'd1);
    chk("mid_re_data", 32'(out_data), 32'h43);
    release_req();
    drain_expect(8'h43);

    // 256 handshakes with the core always ready: counter wraps, no loss.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    mon_en    = 1'b1;
    for (int i = 0; i < 256; i++) begin
      handshake(8'(i) ^ 8'h5A, 20, acked, lat);
      chk("wrap_ack", 32'(acked), 32'd1);
      release_req();
      if (i == 254) begin
        chk("wrap_frame_255", 32'(frame_cnt), 32'd255);
      end
    end
    repeat (4) @(posedge clk);
    #1;
    mon_en    = 1'b0;
    out_ready = 1'b0;
    chk("wrap_frame", 32'(frame_cnt), 32'd0);
    chk("wrap_count", 32'(sb_got.size()), 32'd256);
    for (int i = 0; i < 256; i++) begin
      if (i < sb_got.size()) begin
        chk("wrap_byte", 32'(sb_got[i]), 32'(8'(i) ^ 8'h5A));
      end
    end
    chk("wrap_empty", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uio_byte_rx.md
Name: uio_byte_rx

Overview:
- Receiving end of the parallel byte-handshake link on the uio pins; the sender drives data plus a request, and this block answers with an acknowledge.
- Synchronises the asynchronous request and captures each byte into a small FIFO.
- Presents captured bytes to the core over a valid/ready interface.
- Sits between the uio_in pin bundle and the datapath that consumes ui_in/uio_in operands.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- SYNC_STAGES, 2, flops on pin_req before use; minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset (clk single clock domain).
- pin_data  input  8  byte from sender (uio_in); stable while pin_req high.
- pin_req  input  1  sender request, asynchronous to clk; 4-phase handshake.
- pin_ack  output  1  acknowledge to sender (drives a uio_out bit).
- out_data  output  8  FIFO head byte.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  core accepts head byte this cycle.
- level  output  clog2(DEPTH)+1  current FIFO occupancy.
- frame_cnt  output  8  count of bytes accepted from the pins; wraps 255->0.

Behaviour:
- Reset (async assert, sync release):
  - pin_ack=0, out_valid=0, level=0, frame_cnt=0.
  - FIFO pointers 0, all sync flops 0, FSM in IDLE.
  - out_data=0 while empty.
- req_s is pin_req after SYNC_STAGES flops; only req_s is used by the logic.
- FSM states:
  - IDLE: pin_ack=0. If req_s=1 and FIFO not full -> CAPTURE. If req_s=1 and full, stay in IDLE with ack withheld (backpressure, no data loss).
  - CAPTURE: single cycle. Write pin_data into FIFO, frame_cnt+1 -> ACK.
  - ACK: pin_ack=1 (registered). Hold until req_s=0, then -> IDLE; pin_ack drops the cycle after.
- pin_data is sampled directly, unsynchronised. This is legal because the sender holds it stable from before pin_req rises until pin_ack is seen.
- Latency: pin_req rise to pin_ack=1 is SYNC_STAGES+2 clk edges when not full.
- One write per handshake. A request still high after the ack is never re-captured; a new byte requires req low then high.
- FIFO:
  - Write occurs only in CAPTURE.
  - Read pops when out_valid && out_ready.
  - Simultaneous read and write: level unchanged, both take effect.
  - A read on empty is ignored.
  - Full means level==DEPTH; the FSM never writes when full.
- out_data is the registered head entry. It is valid in the same cycle out_valid=1. A written byte is visible at out_data the cycle after CAPTURE (first-word fall-through, one-cycle latency).
- level width and pointer wrap: pointers are clog2(DEPTH) bits with an extra wrap bit for full/empty.
- Reset mid-handshake:
  - FSM goes to IDLE, pin_ack=0, FIFO contents discarded.
  - If pin_req is still high after release, it is treated as a new request (sender must tolerate a duplicate).
- out_valid is never asserted combinationally from out_ready (no comb path from out_ready to out_valid).

Test Plan:
- Single byte: pin_data=0xA5, raise pin_req, hold until ack, drop -> pin_ack rises 4 clks after req (SYNC_STAGES=2), out_valid=1, out_data=0xA5, level=1, frame_cnt=1.
- Fill and backpressure: out_ready=0, send 0x01..0x05 -> four acks, fifth request sees pin_ack stay 0, level=4. Then pulse out_ready once -> fifth byte acked. Drain order is 01,02,03,04,05.
- Simultaneous: with level=2, hold out_ready=1 while a CAPTURE occurs -> level stays 2, output sequence preserved.
- Held request: keep pin_req high for 20 clks after ack -> exactly one byte written, frame_cnt +1 only.
- Reset mid-handshake: assert rst while in ACK with level=3 -> pin_ack=0, out_valid=0, level=0 immediately (async). Keep pin_req high through release -> one new capture occurs.
- Wrap: 256 handshakes with out_ready=1 -> frame_cnt returns to 0, no byte lost or duplicated (scoreboard).
